// File: rtl/riscv_pkg.sv
// Shared load/store funct3 encodings, access-size decode and the data-memory FSM state encoding.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    typedef struct packed {
        logic      legal;
        acc_size_e size;
        logic      zext;
    } acc_dec_t;

    function automatic acc_dec_t decode_access(input logic is_store, input logic [2:0] f3);
        acc_dec_t d;
        d.legal = 1'b1;
        d.size  = SZ_WORD;
        d.zext  = 1'b0;
        if (is_store) begin
            case (f3)
                F3_SB:   d.size = SZ_BYTE;
                F3_SH:   d.size = SZ_HALF;
                F3_SW:   d.size = SZ_WORD;
                default: d.legal = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_LB:   d.size = SZ_BYTE;
                F3_LH:   d.size = SZ_HALF;
                F3_LW:   d.size = SZ_WORD;
                F3_LBU:  begin d.size = SZ_BYTE; d.zext = 1'b1; end
                F3_LHU:  begin d.size = SZ_HALF; d.zext = 1'b1; end
                default: d.legal = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: byte-lane write enables, asynchronous read.
module dmem_array #(
    parameter int XLEN      = 32,
    parameter int MEM_DEPTH = 1024,
    parameter     INIT_FILE = "",
    localparam int AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic            clk,
    input  logic            we,
    input  logic [3:0]      be,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit with configurable wait states in front of dmem_array.
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned accesses instead of force-aligning them.
//
// state | meaning
// IDLE  | no access in progress; zero-wait accesses complete here
// WAIT  | counting down the remaining wait states
// DONE  | access completes; a store commits on the closing edge
module dmem_access_unit
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            stall,
    output logic            fault
);

    localparam int AW            = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

    dmem_state_e     state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;

    logic            req;
    logic            is_store;
    acc_dec_t        dec;
    logic            misalign;
    logic [1:0]      off;
    logic            req_ok;
    logic            done;
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_lane;
    logic [XLEN-1:0] rword;
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] ext;
    logic [AW-1:0]   widx;

    // A store wins when both strobes are high.
    assign req      = mem_read | mem_write;
    assign is_store = mem_write;
    assign dec      = decode_access(is_store, funct3);

    always_comb begin
        off      = addr[1:0];
        misalign = 1'b0;
        case (dec.size)
`ifdef DMEM_MISALIGN_CHECK_EN
            SZ_HALF: misalign = addr[0];
            SZ_WORD: misalign = |addr[1:0];
`else
            SZ_HALF: off = {addr[1], 1'b0};
            SZ_WORD: off = 2'b00;
`endif
            default: ;
        endcase
    end

    assign fault  = req & (~dec.legal | misalign);
    assign req_ok = req & ~fault;
    assign widx   = AW'((addr >> 2) % XLEN'(MEM_DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    if (WAIT_STATES == 0) begin
                        done = 1'b1;
                    end else begin
                        stall = 1'b1;
                        // The IDLE cycle is the first stall cycle, so WAIT covers the rest.
                        if (WS_M1 == 4'd0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = WS_M1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = req_ok;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        case (dec.size)
            SZ_BYTE: begin
                be         = 4'b0001 << off;
                wdata_lane = {(XLEN/8){wdata[7:0]}};
            end
            SZ_HALF: begin
                be         = 4'b0011 << off;
                wdata_lane = {(XLEN/16){wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // A store landing on the same edge as reset is dropped.
    assign we = done & is_store & rst;

    dmem_array #(
        .XLEN      (XLEN),
        .MEM_DEPTH (MEM_DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .be    (be),
        .addr  (widx),
        .wdata (wdata_lane),
        .rdata (rword)
    );

    always_comb begin
        rshift = rword >> {off, 3'b000};
        ext    = rword;
        case (dec.size)
            SZ_BYTE: ext = dec.zext ? {{(XLEN-8){1'b0}}, rshift[7:0]}
                                    : {{(XLEN-8){rshift[7]}}, rshift[7:0]};
            SZ_HALF: ext = dec.zext ? {{(XLEN-16){1'b0}}, rshift[15:0]}
                                    : {{(XLEN-16){rshift[15]}}, rshift[15:0]};
            default: ;
        endcase
    end

    assign rdata = (done && !is_store) ? ext : '0;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench: three instances (WAIT_STATES 1, 3, 0) driven one at a time with directed accesses.
module tb_dmem_access_unit;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
    localparam logic [2:0] BAD_L = 3'b110, BAD_S = 3'b011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic        rd    [3];
    logic        wr    [3];
    logic [2:0]  f3    [3];
    logic [31:0] addr  [3];
    logic [31:0] wd    [3];
    logic [31:0] rdat  [3];
    logic        stl   [3];
    logic        flt   [3];

    dmem_access_unit #(.XLEN(32), .MEM_DEPTH(1024), .WAIT_STATES(1), .INIT_FILE("")) u_dut_ws1 (
        .clk(clk), .rst(rst_n[0]), .mem_read(rd[0]), .mem_write(wr[0]), .funct3(f3[0]),
        .addr(addr[0]), .wdata(wd[0]), .rdata(rdat[0]), .stall(stl[0]), .fault(flt[0]));

    dmem_access_unit #(.XLEN(32), .MEM_DEPTH(1024), .WAIT_STATES(3), .INIT_FILE("")) u_dut_ws3 (
        .clk(clk), .rst(rst_n[1]), .mem_read(rd[1]), .mem_write(wr[1]), .funct3(f3[1]),
        .addr(addr[1]), .wdata(wd[1]), .rdata(rdat[1]), .stall(stl[1]), .fault(flt[1]));

    dmem_access_unit #(.XLEN(32), .MEM_DEPTH(1024), .WAIT_STATES(0), .INIT_FILE("")) u_dut_ws0 (
        .clk(clk), .rst(rst_n[2]), .mem_read(rd[2]), .mem_write(wr[2]), .funct3(f3[2]),
        .addr(addr[2]), .wdata(wd[2]), .rdata(rdat[2]), .stall(stl[2]), .fault(flt[2]));

    typedef struct {
        int          dut;
        int          tag;
        logic [31:0] rdata;
        logic        fault;
        int          nstall;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   tag_n  = 0;
    int   stall_cnt [3];

    // Monitor: a request with stall low is a response (completion or fault).
    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n[k]) begin
                stall_cnt[k] = 0;
            end else if (rd[k] || wr[k]) begin
                if (stl[k]) begin
                    stall_cnt[k] = stall_cnt[k] + 1;
                end else begin
                    if (expq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_response dut%0d got rdata %h fault %b", k, rdat[k], flt[k]);
                    end else begin
                        e = expq.pop_front();
                        checks++;
                        if (e.dut != k) begin
                            errors++;
                            $display("FAIL response_dut tx%0d got dut%0d exp dut%0d", e.tag, k, e.dut);
                        end
                        checks++;
                        if (rdat[k] !== e.rdata) begin
                            errors++;
                            $display("FAIL rdata dut%0d tx%0d got %h exp %h", k, e.tag, rdat[k], e.rdata);
                        end
                        checks++;
                        if (flt[k] !== e.fault) begin
                            errors++;
                            $display("FAIL fault dut%0d tx%0d got %b exp %b", k, e.tag, flt[k], e.fault);
                        end
                        checks++;
                        if (stall_cnt[k] != e.nstall) begin
                            errors++;
                            $display("FAIL stall_cycles dut%0d tx%0d got %0d exp %0d", k, e.tag, stall_cnt[k], e.nstall);
                        end
                    end
                    stall_cnt[k] = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s dut%0d got %h exp %h", nm, k, got, exp_v);
        end
    endtask

    // Holds the request until the DUT stops stalling, then releases it one edge later.
    task automatic req(input int k, input logic r, input logic w, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ef, input int ens);
        exp_t e;
        bit   seen;
        seen     = 1'b0;
        e.dut    = k;
        e.tag    = tag_n;
        e.rdata  = er;
        e.fault  = ef;
        e.nstall = ens;
        tag_n    = tag_n + 1;
        expq.push_back(e);
        rd[k] = r; wr[k] = w; f3[k] = fn; addr[k] = a; wd[k] = d;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (!stl[k]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL timeout dut%0d tx%0d stall held high", k, e.tag);
            expq.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_chk(input int k);
        rd[k] = 1'b0; wr[k] = 1'b0; f3[k] = 3'b000; addr[k] = 32'h0; wd[k] = 32'h0;
        @(negedge clk);
        chk("idle_stall", k, {31'b0, stl[k]}, 32'h0);
        chk("idle_fault", k, {31'b0, flt[k]}, 32'h0);
        chk("idle_rdata", k, rdat[k], 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
            f3[k] = 3'b000; addr[k] = 32'h0; wd[k] = 32'h0; stall_cnt[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        for (int k = 0; k < 3; k++) idle_chk(k);

        // ---- WAIT_STATES = 1 ----
        req(0, 0, 1, SW,  32'h10, 32'hDEADBEEF, 32'h0,        0, 1);
        req(0, 1, 0, LW,  32'h10, 32'h0,        32'hDEADBEEF, 0, 1);
        req(0, 0, 1, SB,  32'h13, 32'h12345680, 32'h0,        0, 1);
        req(0, 1, 0, LB,  32'h13, 32'h0,        32'hFFFFFF80, 0, 1);
        req(0, 1, 0, LBU, 32'h13, 32'h0,        32'h00000080, 0, 1);
        req(0, 1, 0, LW,  32'h10, 32'h0,        32'h80ADBEEF, 0, 1);
`ifdef DMEM_MISALIGN_CHECK_EN
        req(0, 1, 0, LH,  32'h11, 32'h0,        32'h0,        1, 0);
`else
        req(0, 1, 0, LH,  32'h11, 32'h0,        32'hFFFFBEEF, 0, 1);
`endif
        req(0, 1, 0, LHU, 32'h12, 32'h0,        32'h000080AD, 0, 1);
        idle_chk(0);
        req(0, 1, 0, BAD_L, 32'h10, 32'h0,        32'h0,      1, 0);
        req(0, 0, 1, BAD_S, 32'h10, 32'h01020304, 32'h0,      1, 0);
        req(0, 1, 0, LW,  32'h10, 32'h0,        32'h80ADBEEF, 0, 1);
        req(0, 0, 1, SW,  32'h14, 32'h11223344, 32'h0,        0, 1);
        req(0, 0, 1, SH,  32'h16, 32'hFFFFCAFE, 32'h0,        0, 1);
        req(0, 1, 0, LW,  32'h14, 32'h0,        32'hCAFE3344, 0, 1);
        req(0, 0, 1, SW,  32'h1000, 32'hA5A5A5A5, 32'h0,      0, 1);
        req(0, 1, 0, LW,  32'h0,  32'h0,        32'hA5A5A5A5, 0, 1);
        req(0, 1, 1, SW,  32'h4,  32'h5A5A0001, 32'h0,        0, 1);
        req(0, 1, 0, LW,  32'h4,  32'h0,        32'h5A5A0001, 0, 1);
        req(0, 0, 1, SW,  32'h20, 32'h0,        32'h0,        0, 1);
`ifdef DMEM_MISALIGN_CHECK_EN
        req(0, 0, 1, SW,  32'h22, 32'h77777777, 32'h0,        1, 0);
        req(0, 1, 0, LW,  32'h20, 32'h0,        32'h0,        0, 1);
`else
        req(0, 0, 1, SW,  32'h22, 32'h77777777, 32'h0,        0, 1);
        req(0, 1, 0, LW,  32'h20, 32'h0,        32'h77777777, 0, 1);
`endif
        idle_chk(0);

        // ---- WAIT_STATES = 3, reset aborts a pending store ----
        req(1, 0, 1, SW,  32'h30, 32'h11111111, 32'h0,        0, 3);
        req(1, 1, 0, LW,  32'h30, 32'h0,        32'h11111111, 0, 3);
        idle_chk(1);
        rd[1] = 1'b0; wr[1] = 1'b1; f3[1] = SW; addr[1] = 32'h30; wd[1] = 32'h22222222;
        @(negedge clk);
        chk("abort_stall1", 1, {31'b0, stl[1]}, 32'h1);
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        @(negedge clk);
        chk("abort_stall2", 1, {31'b0, stl[1]}, 32'h1);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        idle_chk(1);
        req(1, 1, 0, LW,  32'h30, 32'h0,        32'h11111111, 0, 3);
        idle_chk(1);

        // ---- WAIT_STATES = 0, back-to-back ----
        req(2, 0, 1, SW,  32'h20, 32'h0BADF00D, 32'h0,        0, 0);
        req(2, 1, 0, LW,  32'h20, 32'h0,        32'h0BADF00D, 0, 0);
        req(2, 1, 0, LB,  32'h20, 32'h0,        32'h0000000D, 0, 0);
        req(2, 1, 0, LB,  32'h21, 32'h0,        32'hFFFFFFF0, 0, 0);
        req(2, 1, 0, LHU, 32'h22, 32'h0,        32'h00000BAD, 0, 0);
        req(2, 0, 1, SB,  32'h23, 32'h000000C3, 32'h0,        0, 0);
        req(2, 1, 0, LW,  32'h20, 32'h0,        32'hC3ADF00D, 0, 0);
        idle_chk(2);

        repeat (2) @(posedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL pending_responses got %0d exp 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
